// File: rtl/alu_arbiter_ctrl.sv
// alu_arbiter_ctrl: two-requester round-robin arbiter sharing one registered 32-bit ALU
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   reqN_valid/op/a/b -> reqN_ready requester N handshake (N = 0, 1), ready is combinational
//   res, res_valid, res_id, res_ovf registered result, DONE-cycle strobe, owner, signed overflow
//   busy                            high whenever the FSM is not IDLE
module alu_arbiter_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic [31:0] res,
  output logic        res_valid,
  output logic        res_id,
  output logic        res_ovf,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t      r_state;
  logic [2:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_id;
  logic        r_last;
  logic        w_idle;
  logic        w_gnt1;
  logic        w_sub;
  logic        w_addsub;
  logic [31:0] w_bm;
  logic [31:0] w_sum;
  logic        w_slt;
  logic        w_sltu;
  logic [31:0] w_res;
  logic        w_ovf;
  // requester 1 wins when alone, or on a tie when requester 0 was granted last
  assign w_idle     = r_state == IDLE;
  assign w_gnt1     = req1_valid & (~req0_valid | ~r_last);
  assign req0_ready = w_idle & req0_valid & ~w_gnt1;
  assign req1_ready = w_idle & w_gnt1;
  assign busy       = ~w_idle;
  always_comb begin
    w_sub    = r_op[2] & r_op[1];
    w_addsub = r_op == 3'b010 || r_op == 3'b110;
    w_bm     = w_sub ? ~r_b : r_b;
    w_sum    = r_a + w_bm + {31'b0, w_sub};
    // differing signs decide SLT directly, so a wrapped difference cannot mislead it
    w_slt    = (r_a[31] ^ r_b[31]) ? r_a[31] : w_sum[31];
    w_sltu   = r_a < r_b;
    w_ovf    = w_addsub & (r_a[31] == w_bm[31]) & (w_sum[31] != r_a[31]);
    w_res    = r_op == 3'b000 ? r_a & r_b :
               r_op == 3'b001 ? r_a | r_b :
               w_addsub       ? w_sum :
               r_op == 3'b111 ? {31'b0, w_slt} :
               r_op == 3'b011 ? {31'b0, w_sltu} :
               r_op == 3'b100 ? ~(r_a | r_b) : r_a ^ r_b;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_id      <= 1'b0;
      r_last    <= 1'b1;
      res       <= '0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (req0_valid | req1_valid) begin
          r_state <= EXEC;
          r_op    <= w_gnt1 ? req1_op : req0_op;
          r_a     <= w_gnt1 ? req1_a : req0_a;
          r_b     <= w_gnt1 ? req1_b : req0_b;
          r_id    <= w_gnt1;
          r_last  <= w_gnt1;
        end
        EXEC: begin
          r_state   <= DONE;
          res       <= w_res;
          res_ovf   <= w_ovf;
          res_id    <= r_id;
          res_valid <= 1'b1;
        end
        DONE: begin
          r_state   <= IDLE;
          res_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// tb_alu_arbiter_ctrl: directed table and sequence checks for alu_arbiter_ctrl
module tb_alu_arbiter_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_ready, req1_ready;
  logic [31:0] res;
  logic        res_valid, res_id, res_ovf, busy;
  int          total = 0, bad = 0;
  typedef struct {
    logic        id;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
  } vec_t;
  vec_t v[15];
  always #5 clk = ~clk;
  alu_arbiter_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res(res), .res_valid(res_valid), .res_id(res_id), .res_ovf(res_ovf), .busy(busy)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", n, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic id, input logic vl, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      req1_valid = vl; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = vl; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask
  initial begin
    int grants[$];
    int nv;
    v[0]  = '{0, 3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1};
    v[1]  = '{1, 3'b110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1};
    v[2]  = '{0, 3'b100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0};
    v[3]  = '{1, 3'b000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0};
    v[4]  = '{0, 3'b001, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 0};
    v[5]  = '{1, 3'b101, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 0};
    v[6]  = '{0, 3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0};
    v[7]  = '{1, 3'b011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0};
    v[8]  = '{0, 3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 0};
    v[9]  = '{1, 3'b111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 0};
    v[10] = '{0, 3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0};
    v[11] = '{1, 3'b110, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 0};
    v[12] = '{0, 3'b011, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 0};
    v[13] = '{0, 3'b111, 32'h00000005, 32'h00000005, 32'h00000000, 0};
    v[14] = '{1, 3'b110, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1};
    step;
    step;
    chk("rst_res", res, 32'h0);
    chk("rst_valid", {31'b0, res_valid}, 32'h0);
    chk("rst_id", {31'b0, res_id}, 32'h0);
    chk("rst_ovf", {31'b0, res_ovf}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    rst_n = 1'b1;
    drv(0, 1, 3'b111, 32'hFFFFFFFF, 32'h1);
    drv(1, 1, 3'b011, 32'hFFFFFFFF, 32'h1);
    #1;
    chk("tie_rdy0", {31'b0, req0_ready}, 32'h1);
    chk("tie_rdy1", {31'b0, req1_ready}, 32'h0);
    step;
    req0_valid = 1'b0;
    #1;
    chk("tie_exec_busy", {31'b0, busy}, 32'h1);
    chk("tie_exec_rdy1", {31'b0, req1_ready}, 32'h0);
    step;
    chk("tie_r0_valid", {31'b0, res_valid}, 32'h1);
    chk("tie_r0_res", res, 32'h1);
    chk("tie_r0_id", {31'b0, res_id}, 32'h0);
    chk("tie_done_rdy1", {31'b0, req1_ready}, 32'h0);
    step;
    chk("tie_idle_rdy1", {31'b0, req1_ready}, 32'h1);
    step;
    req1_valid = 1'b0;
    step;
    chk("tie_r1_valid", {31'b0, res_valid}, 32'h1);
    chk("tie_r1_res", res, 32'h0);
    chk("tie_r1_id", {31'b0, res_id}, 32'h1);
    step;
    drv(0, 1, 3'b010, 32'h1, 32'h1);
    drv(1, 1, 3'b000, 32'h3, 32'h1);
    #1;
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      if (req0_ready && req1_ready) chk("rr_both_ready", 32'h1, 32'h0);
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (res_valid) nv++;
      step;
    end
    drv(0, 0, 3'b000, 32'h0, 32'h0);
    drv(1, 0, 3'b000, 32'h0, 32'h0);
    chk("rr_ngrants", grants.size(), 32'd4);
    chk("rr_nvalid", nv, 32'd4);
    for (int g = 0; g < 4; g++)
      chk($sformatf("rr_grant%0d", g), g < grants.size() ? grants[g] : -1, g % 2);
    drv(0, 1, 3'b010, 32'h1, 32'h2);
    #1;
    chk("late_rdy0", {31'b0, req0_ready}, 32'h1);
    step;
    drv(0, 0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF);
    drv(1, 1, 3'b000, 32'hFF00FF00, 32'h0FF00FF0);
    #1;
    chk("late_exec_rdy1", {31'b0, req1_ready}, 32'h0);
    step;
    chk("late_done_rdy1", {31'b0, req1_ready}, 32'h0);
    chk("late_r0_res", res, 32'h3);
    chk("late_r0_id", {31'b0, res_id}, 32'h0);
    step;
    chk("late_idle_rdy1", {31'b0, req1_ready}, 32'h1);
    step;
    req1_valid = 1'b0;
    step;
    chk("late_r1_valid", {31'b0, res_valid}, 32'h1);
    chk("late_r1_res", res, 32'h0F000F00);
    chk("late_r1_id", {31'b0, res_id}, 32'h1);
    step;
    foreach (v[i]) begin
      drv(v[i].id, 1, v[i].op, v[i].a, v[i].b);
      #1;
      chk($sformatf("v%0d_rdy0", i), {31'b0, req0_ready}, {31'b0, ~v[i].id});
      chk($sformatf("v%0d_rdy1", i), {31'b0, req1_ready}, {31'b0, v[i].id});
      step;
      drv(v[i].id, 0, 3'b000, 32'h0, 32'h0);
      chk($sformatf("v%0d_exec_busy", i), {31'b0, busy}, 32'h1);
      chk($sformatf("v%0d_exec_valid", i), {31'b0, res_valid}, 32'h0);
      step;
      chk($sformatf("v%0d_valid", i), {31'b0, res_valid}, 32'h1);
      chk($sformatf("v%0d_res", i), res, v[i].res);
      chk($sformatf("v%0d_ovf", i), {31'b0, res_ovf}, {31'b0, v[i].ovf});
      chk($sformatf("v%0d_id", i), {31'b0, res_id}, {31'b0, v[i].id});
      step;
      chk($sformatf("v%0d_idle_valid", i), {31'b0, res_valid}, 32'h0);
      chk($sformatf("v%0d_idle_busy", i), {31'b0, busy}, 32'h0);
      chk($sformatf("v%0d_hold_res", i), res, v[i].res);
    end
    drv(0, 1, 3'b010, 32'h5, 32'h6);
    step;
    req0_valid = 1'b0;
    chk("arst_pre_busy", {31'b0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'h0);
    chk("arst_res", res, 32'h0);
    chk("arst_valid", {31'b0, res_valid}, 32'h0);
    chk("arst_id", {31'b0, res_id}, 32'h0);
    chk("arst_ovf", {31'b0, res_ovf}, 32'h0);
    step;
    chk("arst_hold_valid", {31'b0, res_valid}, 32'h0);
    rst_n = 1'b1;
    step;
    chk("arst_post_valid", {31'b0, res_valid}, 32'h0);
    chk("arst_post_busy", {31'b0, busy}, 32'h0);
    drv(0, 1, 3'b010, 32'h1, 32'h1);
    drv(1, 1, 3'b101, 32'h3, 32'h5);
    #1;
    chk("arst_tie_rdy0", {31'b0, req0_ready}, 32'h1);
    chk("arst_tie_rdy1", {31'b0, req1_ready}, 32'h0);
    step;
    drv(0, 0, 3'b000, 32'h0, 32'h0);
    drv(1, 0, 3'b000, 32'h0, 32'h0);
    step;
    chk("arst_new_valid", {31'b0, res_valid}, 32'h1);
    chk("arst_new_res", res, 32'h2);
    chk("arst_new_id", {31'b0, res_id}, 32'h0);
    step;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
